// File: rtl/thumb_halfword_fetch.sv
// Thumb fetch stage: reads one 32-bit word at a time and hands its two
// halfwords to the decoder over a valid/ready handshake, with branch flush.
module thumb_halfword_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_bl_prefix,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HAVE
    } state_t;

    state_t      state, state_nxt;
    logic [31:1] fetch_pc, fetch_pc_nxt;
    logic [31:0] buf_word, buf_word_nxt;

    // Halfword PCs only; the byte bit of a redirect target carries no meaning.
    logic unused_flush_bit;
    assign unused_flush_bit = flush_pc[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= START;
            fetch_pc <= RESET_PC[31:1];
            buf_word <= 32'h0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            buf_word <= buf_word_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        buf_word_nxt = buf_word;

        case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    buf_word_nxt = mem_rdata;
                    state_nxt    = HAVE;
                end
            end
            HAVE: begin
                if (out_ready) begin
                    fetch_pc_nxt = fetch_pc + 31'd1;
                    if (fetch_pc[1]) begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = START;
        endcase

        // A redirect wins over everything, including a read landing this cycle.
        if (flush_i) begin
            fetch_pc_nxt = flush_pc[31:1];
            buf_word_nxt = buf_word;
            state_nxt    = FETCH;
        end
    end

    assign mem_re        = (state == FETCH);
    assign out_valid     = (state == HAVE);
    assign mem_addr      = {fetch_pc[31:2], 2'b00};
    assign out_pc        = {fetch_pc, 1'b0};
    assign out_instr     = fetch_pc[1] ? buf_word[31:16] : buf_word[15:0];
    assign out_bl_prefix = out_valid && (out_instr[15:11] == 5'b11110);

endmodule

// File: tb/tb_thumb_halfword_fetch.sv
// Self-checking bench for thumb_halfword_fetch: behavioural memory, a
// scoreboard of expected halfwords, and directed checks on the fetch side.
module tb_thumb_halfword_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [31:0] out_pc;
    logic        out_bl_prefix;
    logic        out_ready;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    thumb_halfword_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_pc     (flush_pc),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_bl_prefix(out_bl_prefix),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    // Memory image: a few fixed words, a distinct pattern everywhere else.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h0000_0000: w = 32'hF800_F000;
            32'h0000_0008: w = 32'h4770_46C0;
            32'h0000_0010: w = 32'hBEEF_1234;
            default:       w = {(a[15:0] + 16'h2) ^ 16'h5A00, a[15:0] ^ 16'h5A00};
        endcase
        return w;
    endfunction

    function automatic logic [15:0] hwAt(input logic [31:0] pc);
        logic [31:0] w;
        w = memWord({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Data is only meaningful when ready; garbage otherwise exposes early capture.
    assign mem_rdata = mem_ready ? memWord(mem_addr) : 32'hDEAD_DEAD;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input logic [31:0] pc, input int n);
        exp_t e;
        logic [31:0] p;
        p = pc;
        for (int i = 0; i < n; i++) begin
            e.pc    = {p[31:1], 1'b0};
            e.instr = hwAt(e.pc);
            sbq.push_back(e);
            p = p + 32'd2;
        end
    endtask

    // Drives one cycle of inputs, scores any handshake, and returns at the next negedge.
    task automatic applyStimulus(input logic f, input logic [31:0] fpc, input logic ordy,
                                 input logic mrdy, input logic r);
        exp_t e;
        rst       = r;
        flush_i   = f;
        flush_pc  = fpc;
        out_ready = ordy;
        mem_ready = mrdy;
        #1;
        checkOutput("excl", {31'h0, mem_re && out_valid}, 32'h0);
        if (out_valid && out_ready && !flush_i && !rst) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_extra", 32'h1, 32'h0);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_pc", out_pc, e.pc);
                checkOutput("sb_instr", {16'h0, out_instr}, {16'h0, e.instr});
                checkOutput("sb_bl", {31'h0, out_bl_prefix}, {31'h0, e.instr[15:11] == 5'b11110});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; flush_pc = 32'h0; out_ready = 1'b0; mem_ready = 1'b0;

        // Reset then boot
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 1);
        checkOutput("rst_mem_re", {31'h0, mem_re}, 32'h0);
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_bl", {31'h0, out_bl_prefix}, 32'h0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        pushExpect(32'h0, 2);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("boot_re", {31'h0, mem_re}, 32'h1);
        checkOutput("boot_addr", mem_addr, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("boot_instr0", {16'h0, out_instr}, 32'h0000_F000);
        checkOutput("boot_pc0", out_pc, 32'h0);
        checkOutput("boot_bl0", {31'h0, out_bl_prefix}, 32'h1);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("boot_instr1", {16'h0, out_instr}, 32'h0000_F800);
        checkOutput("boot_pc1", out_pc, 32'h2);
        checkOutput("boot_bl1", {31'h0, out_bl_prefix}, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("next_re", {31'h0, mem_re}, 32'h1);
        checkOutput("next_addr", mem_addr, 32'h4);

        // Backpressure on the halfword at 0x8
        pushExpect(32'h4, 2);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 1, 0);
        pushExpect(32'h8, 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 0, 1, 0);
            checkOutput("bp_instr", {16'h0, out_instr}, 32'h0000_46C0);
            checkOutput("bp_pc", out_pc, 32'h8);
            checkOutput("bp_valid", {31'h0, out_valid}, 32'h1);
            checkOutput("bp_re", {31'h0, mem_re}, 32'h0);
        end
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("bp_next_pc", out_pc, 32'hA);

        // Misaligned flush during HAVE
        applyStimulus(0, 32'h0, 1, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("mis_have", {31'h0, out_valid}, 32'h1);
        applyStimulus(1, 32'h0000_0013, 0, 1, 0);
        checkOutput("mis_addr", mem_addr, 32'h10);
        checkOutput("mis_re", {31'h0, mem_re}, 32'h1);
        pushExpect(32'h12, 1);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("mis_pc", out_pc, 32'h12);
        checkOutput("mis_instr", {16'h0, out_instr}, 32'h0000_BEEF);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("mis_next", mem_addr, 32'h14);

        // Wait states
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h0, 1, 0, 0);
            checkOutput("ws_re", {31'h0, mem_re}, 32'h1);
            checkOutput("ws_addr", mem_addr, 32'h14);
            checkOutput("ws_valid", {31'h0, out_valid}, 32'h0);
        end
        pushExpect(32'h14, 2);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("ws_instr", {16'h0, out_instr}, {16'h0, hwAt(32'h14)});
        applyStimulus(0, 32'h0, 1, 1, 0);
        applyStimulus(0, 32'h0, 1, 1, 0);

        // Flush collides with read completion at 0x4
        applyStimulus(1, 32'h4, 0, 0, 0);
        checkOutput("col_addr4", mem_addr, 32'h4);
        applyStimulus(1, 32'h40, 0, 1, 0);
        checkOutput("col_addr40", mem_addr, 32'h40);
        checkOutput("col_valid", {31'h0, out_valid}, 32'h0);
        pushExpect(32'h40, 2);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("col_pc", out_pc, 32'h40);
        checkOutput("col_instr", {16'h0, out_instr}, {16'h0, hwAt(32'h40)});
        applyStimulus(0, 32'h0, 1, 1, 0);
        applyStimulus(0, 32'h0, 1, 1, 0);

        // Reset beats a flush and an in-flight read
        applyStimulus(1, 32'h80, 0, 0, 1);
        checkOutput("rr_re", {31'h0, mem_re}, 32'h0);
        checkOutput("rr_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rr_bl", {31'h0, out_bl_prefix}, 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("rr_addr", mem_addr, 32'h0);
        checkOutput("rr_fetch", {31'h0, mem_re}, 32'h1);

        // PC wrap
        applyStimulus(1, 32'hFFFF_FFFE, 0, 0, 0);
        checkOutput("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        pushExpect(32'hFFFF_FFFE, 1);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFE);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("wrap_next", mem_addr, 32'h0);
        checkOutput("wrap_re", {31'h0, mem_re}, 32'h1);

        // Steady streaming: 8 halfwords in 12 cycles
        pushExpect(32'h0, 8);
        for (int i = 0; i < 12; i++) applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("tp_addr", mem_addr, 32'h10);
        checkOutput("sb_drain", sbq.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thumb_halfword_fetch.md
Name: thumb_halfword_fetch

Overview:
- Thumb-state instruction fetch stage that sits directly upstream of the core decoder.
- Issues 32-bit word reads on the memory interface and buffers one word.
- Presents 16-bit Thumb halfwords with their PC to the decoder over a valid/ready handshake.
- On a branch flush (including the BL suffix redirect), discards buffered and in-flight data and refetches from the new PC; flags BL prefix halfwords so decode can pair them with the following suffix.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [0] are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  redirect request from execute (branch taken)
- flush_pc  in  32  new halfword PC; bit 0 ignored
- mem_addr  out  32  word-aligned read address; bits [1:0] always 0
- mem_re  out  1  read request
- mem_rdata  in  32  read data, valid in a cycle where mem_re && mem_ready
- mem_ready  in  1  read complete this cycle
- out_valid  out  1  halfword available to the decoder
- out_instr  out  16  Thumb instruction halfword
- out_pc  out  32  address of out_instr; bit 0 always 0
- out_bl_prefix  out  1  out_instr[15:11] == 5'b11110, qualified by out_valid
- out_ready  in  1  decoder accepts halfword this cycle

Behaviour:
- Registers:
  - fetch_pc[31:1], the next halfword to deliver.
  - buf_word[31:0].
  - state.
- State encoding: START, FETCH, HAVE.
- Reset (rst high at a clock edge):
  - state = START.
  - fetch_pc = RESET_PC with bit 0 cleared.
  - buf_word = 0.
  - Reset overrides everything, including a flush in the same cycle or a read in flight.
- Output values:
  - START: mem_re = 0, out_valid = 0, out_bl_prefix = 0, mem_addr = {fetch_pc[31:2], 2'b00}.
  - Once rst is released, START moves to FETCH on the next edge, unconditionally.
- FETCH:
  - mem_re = 1, mem_addr = {fetch_pc[31:2], 2'b00}, out_valid = 0.
  - On an edge with mem_ready = 1: buf_word = mem_rdata, state = HAVE.
  - With mem_ready = 0: stay in FETCH, holding the address stable. The number of wait states is unbounded.
- HAVE:
  - mem_re = 0, out_valid = 1, out_pc = {fetch_pc[31:1], 1'b0}.
  - Halfword selection is little-endian: out_instr = fetch_pc[1] ? buf_word[31:16] : buf_word[15:0].
  - On an edge with out_ready = 1, fetch_pc advances by 2 (modulo 2^32; 0xFFFF_FFFE wraps to 0).
    - If fetch_pc[1] was 0: stay in HAVE and deliver the upper half next cycle.
    - If fetch_pc[1] was 1: state = FETCH for the next word.
  - With out_ready = 0: out_instr, out_pc and out_bl_prefix hold stable.
- Flush:
  - flush_i at an edge, in FETCH or HAVE, takes priority over every other event.
  - fetch_pc = flush_pc[31:1], state = FETCH.
  - Any read completing in that same cycle is discarded and not written to buf_word.
  - A halfword handshake in the same cycle is treated by the decoder as squashed; this block takes no further action for it.
  - In START, a flush is honoured: state = FETCH with the new PC.
- Misaligned target: if flush_pc[1] = 1, the fetched word's lower half is skipped and the first delivered halfword is the upper half.
- Latency: a flush at edge N gives mem_re at cycle N+1. With zero wait states, out_valid is high at cycle N+2.
- Throughput: steady state with out_ready held at 1 is 2 halfwords per 3 cycles. No prefetch overlap is required.
- out_bl_prefix is purely combinational from out_instr and out_valid. This block does no pairing logic itself.
- Invariant: mem_re and out_valid are never both 1 in the same cycle.

Test Plan:
1. Reset then boot:
   - Stimulus: RESET_PC = 0, mem word 0 = 32'hF800F000, mem_ready tied high.
   - Required: START for one cycle, then mem_re = 1 with mem_addr = 0.
   - Next cycle: out_instr = 16'hF000, out_pc = 0, out_bl_prefix = 1.
   - Then: out_instr = 16'hF800, out_pc = 2, out_bl_prefix = 0.
   - Then: mem_re = 1 with mem_addr = 4.
2. Backpressure:
   - Stimulus: out_ready = 0 for 3 cycles while in HAVE with pc 0x8 showing 16'h46C0.
   - Required: out_instr, out_pc and out_valid hold unchanged, mem_re = 0 throughout.
   - When out_ready rises, the next halfword is pc 0xA.
3. Misaligned flush:
   - Stimulus: flush_i with flush_pc = 32'h0000_0013 during HAVE; mem word at 0x10 = 32'hBEEF1234.
   - Required: mem_addr = 0x10 on the next cycle.
   - First delivered halfword: out_pc = 0x12, out_instr = 16'hBEEF.
   - Then: mem_addr = 0x14.
4. Wait states:
   - Stimulus: mem_ready low for 4 cycles in FETCH.
   - Required: mem_re and mem_addr held stable for all 5 cycles, out_valid = 0.
   - Data is captured only on the mem_ready = 1 edge.
5. Flush collides with read completion:
   - Stimulus: flush_i to 0x40 in the same cycle as mem_ready = 1 for address 0x4.
   - Required: the word from 0x4 is never presented.
   - Next request is mem_addr = 0x40; first out_pc = 0x40.
6. Reset mid-operation and PC wrap:
   - Stimulus: rst during FETCH with mem_ready = 0 and flush_i = 1 in the same cycle.
   - Required: START follows, outputs are 0, and the next fetch is at RESET_PC.
   - Separately: flush to 0xFFFF_FFFE, consume one halfword; the next fetch is mem_addr = 0.
